// File: rtl/ver_query_pkg.sv
// ============================================================================
// ver_query_pkg : command bytes, status codes and FSM states for ver_query
// Rev 1.0
// ============================================================================
`default_nettype none

package ver_query_pkg;

  localparam logic [7:0] c_cmd_v  = 8'h56;
  localparam logic [7:0] c_cmd_e  = 8'h45;
  localparam logic [7:0] c_cmd_r  = 8'h52;
  localparam logic [7:0] c_cmd_cr = 8'h0d;
  localparam logic [7:0] c_cmd_lf = 8'h0a;
  localparam int         c_cmd_len = 5;

  localparam logic [1:0] c_stat_ok      = 2'b00;
  localparam logic [1:0] c_stat_timeout = 2'b01;
  localparam logic [1:0] c_stat_ovf     = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = c_cmd_v;
      3'd1:    cmd_byte = c_cmd_e;
      3'd2:    cmd_byte = c_cmd_r;
      3'd3:    cmd_byte = c_cmd_cr;
      default: cmd_byte = c_cmd_lf;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_recv.sv
// ============================================================================
// RX_RECV : byte-level UART receiver, 8N1, mid-bit sampling
// Rev 1.0
// ============================================================================
`default_nettype none

module RX_RECV #(
  parameter int SLOOP_MAX = 100,
  parameter int DW        = 8
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          RX,
  output logic          valid,
  output logic [DW-1:0] dot
);

  localparam int SW = $clog2(SLOOP_MAX + 1);
  localparam int BW = $clog2(DW + 2);

  logic [1:0]    r_sync;
  logic          r_busy;
  logic [SW-1:0] r_sloop;
  logic [BW-1:0] r_bitcnt;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic [DW-1:0] r_dot;
  logic          w_rx;
  logic [SW-1:0] w_target;

  assign w_rx     = r_sync[1];
  // Half a bit to reach the centre of the start bit, then whole bits.
  assign w_target = (r_bitcnt == '0) ? SW'(SLOOP_MAX / 2 - 1) : SW'(SLOOP_MAX - 1);

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_sync   <= 2'b11;
      r_busy   <= 1'b0;
      r_sloop  <= '0;
      r_bitcnt <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_dot    <= '0;
    end else begin
      r_sync  <= {r_sync[0], RX};
      r_valid <= 1'b0;
      if (!r_busy) begin
        if (!w_rx) begin
          r_busy   <= 1'b1;
          r_sloop  <= '0;
          r_bitcnt <= '0;
        end
      end else if (r_sloop == w_target) begin
        r_sloop <= '0;
        if (r_bitcnt == '0) begin
          if (w_rx) r_busy <= 1'b0;  // glitch, not a start bit
          else      r_bitcnt <= BW'(1);
        end else if (r_bitcnt == BW'(DW + 1)) begin
          r_busy <= 1'b0;
          if (w_rx) begin
            r_valid <= 1'b1;
            r_dot   <= r_data;
          end
        end else begin
          r_data   <= {w_rx, r_data[DW-1:1]};
          r_bitcnt <= r_bitcnt + BW'(1);
        end
      end else begin
        r_sloop <= r_sloop + SW'(1);
      end
    end
  end

  assign valid = r_valid;
  assign dot   = r_dot;

endmodule

`default_nettype wire

// File: rtl/tx_send.sv
// ============================================================================
// TX_SEND : byte-level UART transmitter, 8N1, SLOOP_MAX clocks per bit
// Rev 1.0
// ============================================================================
`default_nettype none

module TX_SEND #(
  parameter int SLOOP_MAX = 100,
  parameter int DW        = 8
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          wen,
  input  logic [DW-1:0] din,
  output logic          TX,
  output logic          rdy
);

  localparam int SW = $clog2(SLOOP_MAX + 1);
  localparam int BW = $clog2(DW + 2);

  logic          r_busy;
  logic [DW+1:0] r_shift;
  logic [BW-1:0] r_bitcnt;
  logic [SW-1:0] r_sloop;

  // Frame is {stop, data, start}; shifting in ones leaves the line idle high.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_busy   <= 1'b0;
      r_shift  <= '1;
      r_bitcnt <= '0;
      r_sloop  <= '0;
    end else if (!r_busy) begin
      if (wen) begin
        r_busy   <= 1'b1;
        r_shift  <= {1'b1, din, 1'b0};
        r_bitcnt <= '0;
        r_sloop  <= '0;
      end
    end else if (r_sloop == SW'(SLOOP_MAX - 1)) begin
      r_sloop <= '0;
      r_shift <= {1'b1, r_shift[DW+1:1]};
      if (r_bitcnt == BW'(DW + 1)) begin
        r_busy <= 1'b0;
      end else begin
        r_bitcnt <= r_bitcnt + BW'(1);
      end
    end else begin
      r_sloop <= r_sloop + SW'(1);
    end
  end

  assign TX  = r_shift[0];
  assign rdy = !r_busy;

endmodule

`default_nettype wire

// File: rtl/ver_query_rbuf.sv
// ============================================================================
// ver_query_rbuf : reply buffer, single write port, registered read
// Rev 1.0
// ============================================================================
`default_nettype none

module ver_query_rbuf #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge CLK) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Read-before-write: a same-cycle write to raddr returns the old entry.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) r_rdata <= '0;
    else        r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ver_query.sv
// ============================================================================
// ver_query : sends "VER"<CR><LF> over UART and captures the reply line
// Rev 1.0
// ============================================================================
`default_nettype none

module ver_query
  import ver_query_pkg::*;
#(
  parameter int SLOOP_MAX  = 100,
  parameter int DW         = 8,
  parameter int RBUF_DEPTH = 16,
  parameter int TIMEOUT    = 20000
) (
  input  logic                              CLK,
  input  logic                              RST_X,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic [1:0]                        status,
  output logic [$clog2(RBUF_DEPTH+1)-1:0]   rlen,
  input  logic [$clog2(RBUF_DEPTH)-1:0]     raddr,
  output logic [DW-1:0]                     rdata,
  output logic                              TX,
  input  logic                              RX
);

  localparam int AW = $clog2(RBUF_DEPTH);
  localparam int LW = $clog2(RBUF_DEPTH + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_ptr;
  logic [1:0]    r_rdy_cnt;
  logic [31:0]   r_timer;
  logic [1:0]    r_status;
  logic [LW-1:0] r_rlen;

  logic          w_wen;
  logic [DW-1:0] w_din;
  logic          w_tx_rdy;
  logic          w_rx_valid;
  logic [DW-1:0] w_rx_dot;
  logic          w_we;
  logic          w_fin;
  logic [1:0]    w_fin_status;

  assign w_din = DW'(cmd_byte(r_ptr));

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wen        = 1'b0;
    w_we         = 1'b0;
    w_fin        = 1'b0;
    w_fin_status = c_stat_ok;
    busy         = (r_state != ST_IDLE);
    done         = (r_state == ST_FIN);
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (r_rdy_cnt == 2'd2) begin
          w_wen = 1'b1;
          if (r_ptr == 3'(c_cmd_len - 1)) w_state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (w_rx_valid) begin
          if (w_rx_dot == DW'(c_cmd_lf)) begin
            w_fin = 1'b1;
          end else if (w_rx_dot == DW'(c_cmd_cr)) begin
            w_fin = 1'b0;
          end else if (r_rlen < LW'(RBUF_DEPTH)) begin
            w_we = 1'b1;
          end else begin
            w_fin        = 1'b1;
            w_fin_status = c_stat_ovf;
          end
        end else if (r_timer == 32'(TIMEOUT - 1)) begin
          w_fin        = 1'b1;
          w_fin_status = c_stat_timeout;
        end
        if (w_fin) w_state_nxt = ST_FIN;
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_ptr     <= '0;
      r_rdy_cnt <= '0;
      r_timer   <= '0;
      r_status  <= c_stat_ok;
      r_rlen    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ptr     <= '0;
            r_rdy_cnt <= '0;
            r_timer   <= '0;
            r_status  <= c_stat_ok;
            r_rlen    <= '0;
          end
        end
        ST_SEND: begin
          r_timer <= '0;
          if (w_wen) begin
            r_ptr     <= r_ptr + 3'd1;
            r_rdy_cnt <= '0;
          end else if (!w_tx_rdy) begin
            r_rdy_cnt <= '0;
          end else if (r_rdy_cnt != 2'd2) begin
            r_rdy_cnt <= r_rdy_cnt + 2'd1;
          end
        end
        ST_RECV: begin
          r_timer <= w_rx_valid ? 32'd0 : r_timer + 32'd1;
          if (w_we)  r_rlen   <= r_rlen + LW'(1);
          if (w_fin) r_status <= w_fin_status;
        end
        default: begin
          r_timer <= r_timer;
        end
      endcase
    end
  end

  assign status = r_status;
  assign rlen   = r_rlen;

  TX_SEND #(
    .SLOOP_MAX (SLOOP_MAX),
    .DW        (DW)
  ) u_tx_send (
    .CLK   (CLK),
    .RST_X (RST_X),
    .wen   (w_wen),
    .din   (w_din),
    .TX    (TX),
    .rdy   (w_tx_rdy)
  );

  RX_RECV #(
    .SLOOP_MAX (SLOOP_MAX),
    .DW        (DW)
  ) u_rx_recv (
    .CLK   (CLK),
    .RST_X (RST_X),
    .RX    (RX),
    .valid (w_rx_valid),
    .dot   (w_rx_dot)
  );

  ver_query_rbuf #(
    .DEPTH (RBUF_DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_rbuf (
    .CLK   (CLK),
    .RST_X (RST_X),
    .we    (w_we),
    .waddr (r_rlen[AW-1:0]),
    .wdata (w_rx_dot),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_ver_query.sv
// ============================================================================
// tb_ver_query : scoreboard bench for ver_query (UART command and reply capture)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ver_query;

  localparam int SL    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int TO    = 3000;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          RST_X = 1'b0;
  logic          start = 1'b0;
  logic          RX = 1'b1;
  logic [AW-1:0] raddr = '0;
  logic          busy, done, TX;
  logic [1:0]    status;
  logic [LW-1:0] rlen;
  logic [DW-1:0] rdata;

  ver_query #(
    .SLOOP_MAX  (SL),
    .DW         (DW),
    .RBUF_DEPTH (DEPTH),
    .TIMEOUT    (TO)
  ) dut (
    .CLK    (CLK),
    .RST_X  (RST_X),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .status (status),
    .rlen   (rlen),
    .raddr  (raddr),
    .rdata  (rdata),
    .TX     (TX),
    .RX     (RX)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]    st;
    logic [LW-1:0] len;
  } done_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          tx_count = 0;
  int          tx_last_start = 0;
  int          done_count = 0;
  int          done_cyc = 0;
  bit          rd_req = 1'b0;
  logic [7:0]  exp_tx[$];
  done_t       exp_done[$];
  logic [DW-1:0] exp_rd[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n, output bit ab);
    ab = 1'b0;
    repeat (n) begin
      @(negedge CLK);
      if (!RST_X) ab = 1'b1;
    end
  endtask

  // TX line decoder: abandons a frame if reset cuts it short.
  initial begin : tx_mon
    logic [7:0] b;
    bit         ab;
    int         st;
    forever begin
      @(negedge CLK);
      if (RST_X && TX === 1'b0) begin
        st = cyc;
        wait_cyc(SL / 2, ab);
        for (int i = 0; i < 8; i++) begin
          if (!ab) begin
            wait_cyc(SL, ab);
            b[i] = TX;
          end
        end
        if (!ab) wait_cyc(SL, ab);
        if (!ab) begin
          check("tx_stop", 32'(TX), 32'd1);
          tx_count++;
          tx_last_start = st;
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got 0x%0h expected no byte", b);
          end else begin
            check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
          end
        end
      end
    end
  end

  initial begin : done_mon
    done_t e;
    forever begin
      @(negedge CLK);
      if (done === 1'b1) begin
        done_count++;
        done_cyc = cyc;
        check("done_busy", 32'(busy), 32'd1);
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done pulse expected none");
        end else begin
          e = exp_done.pop_front();
          check("done_status", 32'(status), 32'(e.st));
          check("done_rlen", 32'(rlen), 32'(e.len));
        end
      end
    end
  end

  initial begin : rd_mon
    forever begin
      @(posedge CLK);
      if (rd_req) begin
        @(negedge CLK);
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got 0x%0h expected no read", rdata);
        end else begin
          check("rdata", 32'(rdata), 32'(exp_rd.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got no finish expected finish within 2ms");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge CLK);
    RX = 1'b0;
    repeat (SL) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (SL) @(negedge CLK);
    end
    RX = 1'b1;
    repeat (SL) @(negedge CLK);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_count < n && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (tx_count < n) check("wait_tx_timeout", 32'(tx_count), 32'(n));
  endtask

  task automatic wait_done(input int prev, input int budget);
    int k = 0;
    while (done_count <= prev && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (done_count <= prev) check("wait_done_timeout", 32'(done_count), 32'(prev + 1));
  endtask

  task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] e);
    @(negedge CLK);
    raddr = a;
    exp_rd.push_back(e);
    rd_req = 1'b1;
    @(posedge CLK);
    #1 rd_req = 1'b0;
  endtask

  task automatic push_cmd;
    exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h45);
    exp_tx.push_back(8'h52);
    exp_tx.push_back(8'h0d);
    exp_tx.push_back(8'h0a);
  endtask

  initial begin : main
    logic [7:0] reply [6];
    int base;
    int d0;

    // Reset values
    repeat (3) @(negedge CLK);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_rlen", 32'(rlen), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_tx", 32'(TX), 32'd1);
    RST_X = 1'b1;
    repeat (5) @(negedge CLK);

    // Command framing and normal "v1.0" reply
    push_cmd();
    exp_done.push_back('{st: 2'b00, len: LW'(4)});
    pulse_start();
    check("busy_rise", 32'(busy), 32'd1);
    wait_tx(5, 6 * 10 * SL + 200);
    check("busy_send", 32'(busy), 32'd1);
    reply = '{8'h76, 8'h31, 8'h2e, 8'h30, 8'h0d, 8'h0a};
    d0 = done_count;
    for (int i = 0; i < 6; i++) rx_byte(reply[i]);
    wait_done(d0, 200);
    repeat (10 * SL) @(negedge CLK);
    check("tx_idle", 32'(TX), 32'd1);
    check("tx_total", 32'(tx_count), 32'd5);
    check("busy_idle", 32'(busy), 32'd0);
    check("done_once", 32'(done_count), 32'(d0 + 1));
    for (int i = 0; i < 4; i++) read_check(AW'(i), reply[i]);

    // Overflow: 20 printable bytes then LF
    base = tx_count;
    push_cmd();
    exp_done.push_back('{st: 2'b10, len: LW'(16)});
    pulse_start();
    wait_tx(base + 5, 6 * 10 * SL + 200);
    d0 = done_count;
    for (int i = 0; i < 16; i++) rx_byte(8'h41 + 8'(i));
    check("ovf_no_early_done", 32'(done_count), 32'(d0));
    rx_byte(8'h51);
    check("ovf_done_on_17", 32'(done_count), 32'(d0 + 1));
    for (int i = 17; i < 20; i++) rx_byte(8'h41 + 8'(i));
    rx_byte(8'h0a);
    repeat (5) @(negedge CLK);
    check("ovf_done_count", 32'(done_count), 32'(d0 + 1));
    check("ovf_rlen_kept", 32'(rlen), 32'd16);
    check("ovf_status_kept", 32'(status), 32'd2);
    for (int i = 0; i < 16; i++) read_check(AW'(i), 8'h41 + 8'(i));

    // Start while busy is ignored
    base = tx_count;
    push_cmd();
    exp_done.push_back('{st: 2'b00, len: LW'(0)});
    pulse_start();
    wait_tx(base + 1, 2 * 10 * SL + 200);
    pulse_start();
    wait_tx(base + 5, 6 * 10 * SL + 200);
    d0 = done_count;
    rx_byte(8'h0d);
    rx_byte(8'h0a);
    wait_done(d0, 200);
    repeat (2 * 10 * SL) @(negedge CLK);
    check("sbusy_tx_total", 32'(tx_count), 32'(base + 5));
    check("sbusy_done_once", 32'(done_count), 32'(d0 + 1));

    // Timeout with RX idle
    base = tx_count;
    push_cmd();
    exp_done.push_back('{st: 2'b01, len: LW'(0)});
    pulse_start();
    wait_tx(base + 5, 6 * 10 * SL + 200);
    d0 = done_count;
    wait_done(d0, TO + 200);
    check("timeout_latency", 32'(done_cyc - tx_last_start), 32'(TO));
    repeat (5) @(negedge CLK);
    check("timeout_status_held", 32'(status), 32'd1);

    // Reset during SEND after two bytes
    base = tx_count;
    push_cmd();
    pulse_start();
    wait_tx(base + 2, 3 * 10 * SL + 200);
    repeat (SL / 2 + 6) @(negedge CLK);
    d0 = done_count;
    RST_X = 1'b0;
    @(negedge CLK);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_tx", 32'(TX), 32'd1);
    check("rstmid_status", 32'(status), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    repeat (4) @(negedge CLK);
    exp_tx.delete();
    RST_X = 1'b1;
    repeat (5) @(negedge CLK);
    check("rstmid_no_done", 32'(done_count), 32'(d0));
    check("rstmid_tx_count", 32'(tx_count), 32'(base + 2));
    base = tx_count;
    push_cmd();
    exp_done.push_back('{st: 2'b00, len: LW'(1)});
    pulse_start();
    wait_tx(base + 5, 6 * 10 * SL + 200);
    rx_byte(8'h37);
    rx_byte(8'h0a);
    wait_done(d0, 200);
    read_check('0, 8'h37);
    repeat (3) @(negedge CLK);

    check("sb_tx_empty", 32'(exp_tx.size()), 32'd0);
    check("sb_done_empty", 32'(exp_done.size()), 32'd0);
    check("sb_rd_empty", 32'(exp_rd.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ver_query.md
# ver_query

UART-side initiator of the version-query exchange. On a `start` pulse it serializes the command "VER"<CR><LF> on `TX`, then collects the reply line arriving on `RX` into a small reply buffer. It reports completion with a status code. It sits on the host/test side of the link, opposite the version responder, and reuses the codebase's `TX_SEND` and `RX_RECV` byte-level UART blocks.

## Interface
- `SLOOP_MAX`, 100: clock cycles per UART bit; passed unchanged to `TX_SEND` and `RX_RECV`.
- `DW`, 8: UART data width.
- `RBUF_DEPTH`, 16: reply buffer depth in bytes; must be a power of two.
- `TIMEOUT`, 20000: idle-cycle limit while waiting for a reply byte.

- `CLK`  in  1: single clock.
- `RST_X`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to run a query; honoured only in IDLE.
- `busy`  out  1: high from the cycle after an accepted `start` until the cycle `done` pulses, inclusive.
- `done`  out  1: one-cycle completion pulse.
- `status`  out  2: result, held until the next accepted `start`. 00 = OK, 01 = timeout, 10 = overflow.
- `rlen`  out  $clog2(RBUF_DEPTH+1): number of stored reply bytes.
- `raddr`  in  $clog2(RBUF_DEPTH): reply buffer read address.
- `rdata`  out  DW: buffer content at `raddr`, registered, 1-cycle read latency.
- `TX`  out  1: serial out, idle high.
- `RX`  in  1: serial in, idle high.

## Operation
- States: IDLE, SEND, RECV, FIN.
- IDLE:
  - `start`=1 clears `rlen`, `status` and the byte pointer (ptr=0), then goes to SEND.
  - `start` in any other state is ignored.
- SEND: the command sequence is 0x56, 0x45, 0x52, 0x0d, 0x0a.
  - A byte is issued by pulsing `TX_SEND.wen` for one cycle with `din`=cmd[ptr]. It is issued only after `TX_SEND.rdy` has been sampled high on 2 consecutive cycles; that count restarts at 0 after each `wen`.
  - ptr increments on each `wen`.
  - The cycle after the 5th `wen`, the FSM goes to RECV and clears the timer.
- RECV: on `RX_RECV.valid`:
  - `dot`=0x0a: go to FIN with status OK.
  - `dot`=0x0d: discard.
  - Any other byte with `rlen` < RBUF_DEPTH: write buf[rlen]=dot, then `rlen`++.
  - Any other byte with `rlen` = RBUF_DEPTH: go to FIN with status overflow; the byte is discarded.
  - Each valid clears the timer. Otherwise the timer increments each cycle. When timer = TIMEOUT-1 with no valid, go to FIN with status timeout.
- FIN: `done`=1 for exactly one cycle, `busy`=1, then return to IDLE.
- `valid` seen in IDLE, SEND or FIN is dropped. `rlen` and buffer contents are retained until the next `start`.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `status`=00, `rlen`=0, `rdata`=0, `TX`=1, internal `wen`=0, timer=0, ptr=0.
- Buffer RAM is not reset.
- `busy` rises 1 cycle after the accepted `start`.
- `done` occurs 1 cycle after the terminating event: LF valid, overflow byte valid, or timer expiry.
- `status` and `rlen` are final on the `done` cycle.
- A valid that arrives in the same cycle as timer expiry wins; the timer expiry is ignored.
- `rdata` updates 1 cycle after `raddr` changes. A same-cycle write to the addressed entry returns the old data.
- Asserting `RST_X` at any time (mid-SEND or mid-RECV) aborts immediately to the reset values. No `done` is produced.
- Timer width: 32 bits. It saturates logically because the FSM leaves RECV at TIMEOUT-1.

## Structure
- `ver_query_pkg`: command byte constants (V, E, R, CR, LF), command length 5, status codes, and the state enum.
- One sub-module: `ver_query_rbuf`, an RBUF_DEPTH×DW single-write, registered-read buffer.
- `TX_SEND` and `RX_RECV` are instantiated directly in the top.

## Test plan
- Command framing: `start` → bench UART decoder sees exactly 0x56, 0x45, 0x52, 0x0d, 0x0a on `TX`, then `TX` stays high; `busy`=1 throughout.
- Normal reply: responder model sends "v1.0"<CR><LF> → one `done` pulse, `status`=00, `rlen`=4, `raddr` 0..3 reads 0x76, 0x31, 0x2e, 0x30.
- Timeout: `RX` held high → `done` occurs TIMEOUT cycles after entering RECV, `status`=01, `rlen`=0.
- Overflow: reply is 20 printable bytes then LF → `status`=10, `rlen`=16, buffer holds the first 16 bytes, and `done` fires on the 17th byte.
- Start while busy: second `start` pulse issued during SEND → ignored; exactly 5 bytes are sent and exactly one `done` pulse occurs.
- Reset mid-SEND (after 2 bytes): `RST_X` low → `busy`=0, `TX`=1, `status`=00, no `done`. A fresh `start` after release sends the full 5-byte command.
